// File: rtl/left_shift_pkg.sv
// Shared types and sizing helpers for the MSB-first serial deserializer.
package left_shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DW_DEFAULT = 4;

  // Bit counter width; never narrower than one bit.
  function automatic int cnt_w(input int dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/left_shift_deser_if.sv
// Parallel word output with valid/ready handshake.
interface left_shift_deser_if
  import left_shift_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic [DW-1:0] q;
  logic          q_valid;
  logic          q_ready;

  modport master (output q, output q_valid, input q_ready);
  modport slave  (input q, input q_valid, output q_ready);

endinterface

// File: rtl/left_shift_deser.sv
// Serial-to-parallel receiver: MSB-first stream with frame-start marker,
// registered valid/ready word output, framing-error pulse and sticky overrun.
module left_shift_deser
  import left_shift_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              data_l,
  left_shift_deser_if.master out_if,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int               CNT_W    = cnt_w(DW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     word_q, word_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              done;
  logic [DW-1:0]     sr_shift;

  assign sr_shift = {sr_q[DW-2:0], data_l};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ferr_d  = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Bits without a frame marker are dropped silently while idle.
        if (en && sync) begin
          sr_d    = sr_shift;
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          sr_d = sr_shift;
          if (sync) begin
            cnt_d  = CNT_ONE;
            ferr_d = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

  // Output register: a completion always wins and overwrites any pending word.
  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (done) begin
      word_d = sr_shift;
      vld_d  = 1'b1;
      if (vld_q && !out_if.q_ready) ovr_d = 1'b1;
    end else if (vld_q && out_if.q_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_if.q       = word_q;
  assign out_if.q_valid = vld_q;
  assign busy           = busy_q;
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_left_shift_deser.sv
// Randomised and directed bench for left_shift_deser against a bit-queue model.
module tb_left_shift_deser;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  logic en = 1'b0, sync = 1'b0, data_l = 1'b0;
  logic busy, frame_err, overrun;

  left_shift_deser_if #(.DW(DW)) bus ();

  left_shift_deser #(.DW(DW)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .en         (en),
    .sync       (sync),
    .data_l     (data_l),
    .out_if     (bus.master),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: collected bits of the current frame, MSB first.
  bit          m_bits[$];
  bit          m_active;
  logic [DW-1:0] m_q;
  bit          m_vld, m_ferr, m_ovr;
  bit          m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_active = 0;
    m_q = '0;
    m_vld = 0;
    m_ferr = 0;
    m_ovr = 0;
    m_done = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit d, input bit rdy);
    logic [DW-1:0] w;
    bit complete = 0;
    m_ferr = 0;
    if (e) begin
      if (s) begin
        m_ferr = m_active;
        m_bits.delete();
        m_bits.push_back(d);
        m_active = 1;
      end else if (m_active) begin
        m_bits.push_back(d);
        if (m_bits.size() == DW) begin
          w = '0;
          foreach (m_bits[i]) w = {w[DW-2:0], m_bits[i]};
          m_bits.delete();
          m_active = 0;
          complete = 1;
          if (m_vld && !rdy) m_ovr = 1;
          m_q = w;
          m_vld = 1;
        end
      end
    end
    if (!complete && m_vld && rdy) m_vld = 0;
    m_done = complete;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},         32'(bus.q),     32'(m_q));
    check({tag, ".q_valid"},   32'(bus.q_valid), 32'(m_vld));
    check({tag, ".busy"},      32'(busy),      32'(m_active));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
  endtask

  task automatic step(input string tag, input bit e, input bit s, input bit d, input bit rdy);
    @(negedge clk);
    en = e; sync = s; data_l = d; bus.q_ready = rdy;
    @(posedge clk);
    model_edge(e, s, d, rdy);
    #1;
    compare_all(tag);
  endtask

  task automatic send_word(input string tag, input logic [DW-1:0] w,
                           input bit rdy_first, input bit rdy_last);
    logic [DW-1:0] sh = w;
    for (int i = 0; i < DW; i++) begin
      step(tag, 1'b1, (i == 0), sh[DW-1], (i == DW-1) ? rdy_last : rdy_first);
      sh = sh << 1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    async_rst_n = 1'b0;
    en = 0; sync = 0; data_l = 0; bus.q_ready = 0;
    #1;
    model_reset();
    check({tag, ".rst_q"},    32'(bus.q),       32'd0);
    check({tag, ".rst_vld"},  32'(bus.q_valid), 32'd0);
    check({tag, ".rst_busy"}, 32'(busy),        32'd0);
    check({tag, ".rst_ferr"}, 32'(frame_err),   32'd0);
    check({tag, ".rst_ovr"},  32'(overrun),     32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] sent[$];
    logic [DW-1:0] w, sh, exp_w;
    bus.q_ready = 1'b0;
    model_reset();

    // 1: basic word and consume
    do_reset("t1");
    step("t1", 1, 1, 1, 0);
    step("t1", 1, 0, 0, 0);
    step("t1", 1, 0, 1, 0);
    step("t1", 1, 0, 1, 0);
    check("t1.word", 32'(bus.q), 32'hB);
    check("t1.vld", 32'(bus.q_valid), 32'd1);
    step("t1", 0, 0, 0, 1);
    check("t1.consumed", 32'(bus.q_valid), 32'd0);
    check("t1.hold", 32'(bus.q), 32'hB);

    // 2: gap mid-word, then stray bits while idle
    step("t2", 1, 1, 0, 0);
    step("t2", 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("t2gap", 0, 0, 1, 0);
      check("t2.busy_gap", 32'(busy), 32'd1);
    end
    step("t2", 1, 0, 1, 0);
    step("t2", 1, 0, 0, 0);
    check("t2.word", 32'(bus.q), 32'h6);
    step("t2", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("t2idle", 1, 0, 1, 0);
    check("t2.idle_vld", 32'(bus.q_valid), 32'd0);

    // 3: resync mid-word
    step("t3", 1, 1, 1, 0);
    step("t3", 1, 0, 0, 0);
    step("t3", 1, 1, 1, 0);
    check("t3.ferr_pulse", 32'(frame_err), 32'd1);
    step("t3", 1, 0, 1, 0);
    check("t3.ferr_clear", 32'(frame_err), 32'd0);
    check("t3.no_vld", 32'(bus.q_valid), 32'd0);
    step("t3", 1, 0, 0, 0);
    step("t3", 1, 0, 0, 0);
    check("t3.word", 32'(bus.q), 32'hC);
    step("t3", 0, 0, 0, 1);

    // 4: overrun and its avoidance
    do_reset("t4a");
    send_word("t4a", 4'hA, 0, 0);
    send_word("t4a", 4'h5, 0, 0);
    check("t4a.word", 32'(bus.q), 32'h5);
    check("t4a.ovr", 32'(overrun), 32'd1);
    do_reset("t4b");
    send_word("t4b", 4'hA, 0, 0);
    send_word("t4b", 4'h5, 0, 1);
    check("t4b.word", 32'(bus.q), 32'h5);
    check("t4b.ovr", 32'(overrun), 32'd0);

    // 5: async reset mid-word with a pending word
    do_reset("t5pre");
    send_word("t5", 4'h3, 0, 0);
    step("t5", 1, 1, 1, 0);
    step("t5", 1, 0, 1, 0);
    do_reset("t5");
    send_word("t5", 4'h9, 0, 0);
    check("t5.word", 32'(bus.q), 32'h9);

    // 6: random serializer traffic with random gaps, consumer always ready
    do_reset("t6");
    for (int n = 0; n < 80; n++) begin
      w = DW'($urandom);
      sent.push_back(w);
      sh = w;
      for (int b = 0; b < DW; b++) begin
        int gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
        for (int g = 0; g < gap; g++) step("t6gap", 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
        step("t6", 1, (b == 0), sh[DW-1], 1);
        sh = sh << 1;
        if (m_done) begin
          exp_w = sent.pop_front();
          check("t6.word", 32'(bus.q), 32'(exp_w));
        end
      end
    end
    check("t6.all_recv", 32'(sent.size()), 32'd0);
    check("t6.ferr", 32'(frame_err), 32'd0);
    check("t6.ovr", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
